// File: rtl/adder_pipe_acc.sv
// Pipelined add/subtract/saturating-accumulate unit with a valid/ready handshake on both sides.
// The result is formed in the accept cycle; the remaining stages only delay {valid, out, ovf}.
module adder_pipe_acc #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             ovf
);

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

  localparam logic [WIDTH:0] MAX = '1;

  logic             en_s;
  logic [WIDTH:0]   a_s;
  logic [WIDTH:0]   b_s;
  logic [WIDTH+2:0] sum_s;
  logic [WIDTH:0]   res_d;
  logic             ovf_d;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH:0]   acc_q;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] ovf_q;
  logic [WIDTH:0]   res_q [STAGES];

  // One global enable: the whole pipe advances only when the output slot can drain.
  assign en_s     = ~out_valid | out_ready;
  assign in_ready = en_s;

  assign a_s   = {1'b0, in1};
  assign b_s   = {1'b0, in2};
  assign sum_s = {2'b00, acc_q} + {2'b00, a_s} + {2'b00, b_s};

  // Stage-0 arithmetic and next accumulator value for the beat being offered.
  always_comb begin
    res_d = a_s + b_s;
    ovf_d = 1'b0;
    acc_d = acc_q;
    case (mode_e'(mode))
      MODE_ADD: begin
        res_d = a_s + b_s;
        ovf_d = 1'b0;
      end
      MODE_SUB: begin
        res_d = a_s - b_s;
        ovf_d = (b_s > a_s);
      end
      MODE_ACC: begin
        if (sum_s > {2'b00, MAX}) begin
          acc_d = MAX;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum_s[WIDTH:0];
          ovf_d = 1'b0;
        end
        res_d = acc_d;
      end
      MODE_LOAD: begin
        acc_d = a_s + b_s;
        res_d = acc_d;
        ovf_d = 1'b0;
      end
      default: begin
        res_d = a_s + b_s;
        ovf_d = 1'b0;
      end
    endcase
  end

  // Accumulator: written only when an ACC or LOAD beat is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (en_s && in_valid && ((mode == MODE_ACC) || (mode == MODE_LOAD))) begin
      acc_q <= acc_d;
    end
  end

  // Stage 0 captures the computed result; data only moves with a valid beat so it holds across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q[0] <= 1'b0;
      res_q[0] <= '0;
      ovf_q[0] <= 1'b0;
    end else if (en_s) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        res_q[0] <= res_d;
        ovf_q[0] <= ovf_d;
      end
    end
  end

  for (genvar s = 1; s < STAGES; s++) begin : g_delay
    // Pure delay stage; bubbles shift through rather than collapse.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q[s] <= 1'b0;
        res_q[s] <= '0;
        ovf_q[s] <= 1'b0;
      end else if (en_s) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          res_q[s] <= res_q[s-1];
          ovf_q[s] <= ovf_q[s-1];
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out       = res_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_adder_pipe_acc.sv
// Bench for adder_pipe_acc: directed table, stall/reset sequences, random traffic against a
// queue-based reference model, and latency/throughput checks on STAGES=1 and STAGES=4 builds.
module tb_adder_pipe_acc;
  localparam int W    = 8;
  localparam int STG  = 2;
  localparam int MAXV = (1 << (W + 1)) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [1:0]   mode;
  logic [W-1:0] in1, in2;
  logic [W:0]   out;
  logic         in_valid_x, in_ready1, out_valid1, ovf1, in_ready4, out_valid4, ovf4;
  logic [W:0]   out1, out4;

  adder_pipe_acc #(.WIDTH(W), .STAGES(STG)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf));

  adder_pipe_acc #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid_x), .in_ready(in_ready1), .mode(mode),
    .in1(in1), .in2(in2), .out_valid(out_valid1), .out_ready(1'b1), .out(out1), .ovf(ovf1));

  adder_pipe_acc #(.WIDTH(W), .STAGES(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid_x), .in_ready(in_ready4), .mode(mode),
    .in1(in1), .in2(in2), .out_valid(out_valid4), .out_ready(1'b1), .out(out4), .ovf(ovf4));

  typedef struct {
    int m;
    int a;
    int b;
    int eo;
    int ev;
  } vec_t;
  vec_t tab[14];

  int         n_vec = 0;
  int         n_err = 0;
  int         acc_m = 0;
  int         ecnt  = 0;
  int         n_fire = 0;
  int         n_stall = 0;
  int         stall_left = 0;
  int         f0;
  bit         use_tab = 1'b1;
  bit         d;
  logic [W:0] pend_out;
  logic       pend_ovf;
  logic [W:0] exp_q[$];
  logic       exp_ovf_q[$];
  int         exp_e_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mode rules, accumulator kept as an int.
  function automatic void model(input int m, input int a, input int b, output int r, output int v);
    int s;
    r = 0;
    v = 0;
    case (m)
      0: r = a + b;
      1: begin
        r = (a - b) & MAXV;
        v = (b > a) ? 1 : 0;
      end
      2: begin
        s = acc_m + a + b;
        v = (s > MAXV) ? 1 : 0;
        acc_m = (s > MAXV) ? MAXV : s;
        r = acc_m;
      end
      default: begin
        acc_m = a + b;
        r = acc_m;
      end
    endcase
  endfunction

  // One clock of the main DUT: score handshakes just before the edge, step, settle.
  task automatic cycle(output bit accepted);
    int r, v, le;
    logic [W:0] eo;
    logic ev;
    accepted = 1'b0;
    #1;
    if (!reset) begin
      check("in_ready", in_ready, (!out_valid || out_ready));
      if (!in_ready) n_stall++;
      if (out_valid && out_ready) begin
        n_fire++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got out=%0d, expected no beat", out);
        end else begin
          eo = exp_q.pop_front();
          ev = exp_ovf_q.pop_front();
          le = exp_e_q.pop_front();
          check("out", out, eo);
          check("ovf", ovf, ev);
          check("latency", ecnt - le, STG);
        end
      end
      if (in_valid && in_ready) begin
        accepted = 1'b1;
        model(int'(mode), int'(in1), int'(in2), r, v);
        exp_q.push_back(use_tab ? pend_out : r[W:0]);
        exp_ovf_q.push_back(use_tab ? pend_ovf : v[0]);
        exp_e_q.push_back(ecnt);
      end
      if (in_ready) ecnt++;
    end
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) out_ready = 1'b1;
    end
  endtask

  task automatic send(input int m, input int a, input int b, input int eo, input int ev);
    bit got;
    got = 1'b0;
    mode = m[1:0];
    in1 = a[W-1:0];
    in2 = b[W-1:0];
    pend_out = eo[W:0];
    pend_ovf = ev[0];
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) cycle(got);
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no accept, expected accept within 50 cycles");
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) cycle(d);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    tab[0]  = '{0, 255, 255, 510, 0};
    tab[1]  = '{1, 3, 5, 510, 1};
    tab[2]  = '{1, 200, 55, 145, 0};
    tab[3]  = '{3, 100, 0, 100, 0};
    tab[4]  = '{2, 200, 100, 400, 0};
    tab[5]  = '{2, 50, 0, 450, 0};
    tab[6]  = '{2, 60, 0, 510, 0};   // 450+60 = 510, still below MAX
    tab[7]  = '{2, 1, 0, 511, 0};    // lands exactly on MAX: not an overflow
    tab[8]  = '{2, 5, 0, 511, 1};
    tab[9]  = '{2, 1, 0, 511, 1};
    tab[10] = '{3, 0, 0, 0, 0};
    tab[11] = '{0, 0, 255, 255, 0};
    tab[12] = '{1, 0, 255, 257, 1};
    tab[13] = '{1, 255, 255, 0, 0};

    reset = 1'b1;
    in_valid = 1'b0;
    in_valid_x = 1'b0;
    out_ready = 1'b1;
    mode = 2'd0;
    in1 = '0;
    in2 = '0;
    #2;
    check("rst_out", out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_valid", out_valid, 0);
    check("rst_valid1", out_valid1, 0);
    check("rst_valid4", out_valid4, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single ADD: valid exactly two cycles after accept, for one cycle.
    send(tab[0].m, tab[0].a, tab[0].b, tab[0].eo, tab[0].ev);
    in_valid = 1'b0;
    check("t1_valid_c1", out_valid, 0);
    cycle(d);
    check("t1_valid_c2", out_valid, 1);
    check("t1_out", out, 510);
    check("t1_ovf", ovf, 0);
    cycle(d);
    check("t1_valid_c3", out_valid, 0);

    // Table: SUB wrap/borrow, LOAD and saturating ACC chain, back-to-back.
    for (int i = 1; i < 14; i++) send(tab[i].m, tab[i].a, tab[i].b, tab[i].eo, tab[i].ev);
    drain();

    // Stream with a three-cycle output stall mid-way.
    f0 = n_fire;
    n_stall = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        out_ready = 1'b0;
        stall_left = 3;
      end
      send(0, i, i, 2 * i, 0);
    end
    drain();
    check("stall_in_ready_dropped", (n_stall > 0), 1);
    check("stall_beat_count", n_fire - f0, 8);

    // Reset with two beats in flight behind a LOAD.
    send(3, 50, 0, 50, 0);
    send(0, 1, 1, 2, 0);
    send(0, 2, 2, 4, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_out", out, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_valid", out_valid, 0);
    exp_q.delete();
    exp_ovf_q.delete();
    exp_e_q.delete();
    acc_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(d);
      check("midrst_no_spurious", out_valid, 0);
    end
    send(2, 1, 1, 2, 0);
    drain();

    // Random traffic with random backpressure, checked against the model.
    use_tab = 1'b0;
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      in1 = 8'($urandom);
      in2 = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(d);
    end
    out_ready = 1'b1;
    drain();

    // STAGES=1 / STAGES=4: single ADD 7,9 latency, then a 10-beat full-rate stream.
    in_valid = 1'b0;
    mode = 2'd0;
    in1 = 8'd7;
    in2 = 8'd9;
    in_valid_x = 1'b1;
    #1;
    check("x_ready1", in_ready1, 1);
    check("x_ready4", in_ready4, 1);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      in_valid_x = 1'b0;
      check("lat1_valid", out_valid1, (j == 0));
      check("lat4_valid", out_valid4, (j == 3));
      if (j == 0) check("lat1_out", out1, 16);
      if (j == 3) check("lat4_out", out4, 16);
    end
    for (int t = 0; t < 14; t++) begin
      if (t < 10) begin
        in_valid_x = 1'b1;
        in1 = t[W-1:0];
        in2 = t[W-1:0];
      end else begin
        in_valid_x = 1'b0;
      end
      #1;
      if (t < 10) begin
        check("tp_ready1", in_ready1, 1);
        check("tp_ready4", in_ready4, 1);
      end
      @(posedge clk);
      #1;
      check("tp_valid1", out_valid1, (t < 10));
      if (t < 10) check("tp_out1", out1, 2 * t);
      check("tp_valid4", out_valid4, (t >= 3 && t < 13));
      if (t >= 3 && t < 13) check("tp_out4", out4, 2 * (t - 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
